mem_port_arbiter: RTL and testbench

Arbitrates port B of the shared 18-bit × 16K program/data memory between three requesters: CPU load/store (0), VGA glyph-map fetcher (1) and gun-status logger (2). Accesses are pipelined at up to one per cycle. Each requester gets a grant pulse and, for reads, a tagged read-data return two cycles after its request is accepted. The block sits between the requesters and the memory's port B, in place of a direct CPU connection.

---
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory port-B bundle for mem_port_arbiter.
// The arbiter uses the slave modport. The requesters and the memory model use master.
interface mem_port_arbiter_if #(
  parameter int DATA = 18,
  parameter int ADDR = 14
);
  logic [2:0]        req;
  logic [2:0]        wr;
  logic [47:0]       addr;
  logic [3*DATA-1:0] din;
  logic [2:0]        gnt;
  logic [2:0]        rvalid;
  logic [DATA-1:0]   rdata;
  logic [2:0]        err;
  logic              mem_wr;
  logic [ADDR-1:0]   mem_addr;
  logic [DATA-1:0]   mem_din;
  logic [DATA-1:0]   mem_dout;

  modport slave (
    input  req, wr, addr, din, mem_dout,
    output gnt, rvalid, rdata, err, mem_wr, mem_addr, mem_din
  );

  modport master (
    output req, wr, addr, din, mem_dout,
    input  gnt, rvalid, rdata, err, mem_wr, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way port-B arbiter with a registered grant, a one-stage read return and sticky range errors.
// Defining ARB_CPU_PRIORITY_EN gives requester 0 absolute priority; requesters 1 and 2 then round-robin.
module mem_port_arbiter #(
  parameter int DATA = 18,
  parameter int ADDR = 14
) (
  input  logic              CLK,
  input  logic              CLR,
  mem_port_arbiter_if.slave bus
);

  logic [2:0]      gnt_q, gnt_d;
  logic [1:0]      last_q, last_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [DATA-1:0] din_q, din_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic            oor_q, oor_d;
  logic [2:0]      rvalid_q, rvalid_d;
  logic            rerr_q, rerr_d;
  logic [2:0]      err_q, err_d;

  logic [2:0]      eligible;
  logic            win_valid;
  logic [1:0]      win_id;
  logic [15:0]     sel_addr;
  logic [DATA-1:0] sel_din;
  logic            sel_wr;
  logic            sel_oor;

  // A requester is not eligible in its own grant cycle, even if it still holds req.
  assign eligible = bus.req & ~gnt_q;

`ifndef ARB_CPU_PRIORITY_EN
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    win_valid = 1'b0;
    win_id    = 2'd0;
`ifdef ARB_CPU_PRIORITY_EN
    if (eligible[0]) begin
      win_valid = 1'b1;
      win_id    = 2'd0;
    end else if (eligible[1] && eligible[2]) begin
      win_valid = 1'b1;
      win_id    = (last_q == 2'd1) ? 2'd2 : 2'd1;
    end else if (eligible[1]) begin
      win_valid = 1'b1;
      win_id    = 2'd1;
    end else if (eligible[2]) begin
      win_valid = 1'b1;
      win_id    = 2'd2;
    end
`else
    begin
      logic [1:0] cand;
      cand = last_q;
      for (int k = 0; k < 3; k++) begin
        cand = rr_next(cand);
        if (!win_valid && eligible[cand]) begin
          win_valid = 1'b1;
          win_id    = cand;
        end
      end
    end
`endif
  end

  assign sel_addr = bus.addr[int'(win_id)*16 +: 16];
  assign sel_din  = bus.din[int'(win_id)*DATA +: DATA];
  assign sel_wr   = bus.wr[win_id];
  assign sel_oor  = |sel_addr[15:ADDR];

  always_comb begin
    gnt_d    = win_valid ? (3'b001 << win_id) : 3'b000;
    addr_d   = win_valid ? sel_addr[ADDR-1:0] : addr_q;
    din_d    = win_valid ? sel_din : din_q;
    wr_d     = win_valid & sel_wr & ~sel_oor;
    rd_d     = win_valid & ~sel_wr;
    oor_d    = win_valid & sel_oor;
    err_d    = err_q | (oor_d ? gnt_d : 3'b000);
    rvalid_d = rd_q ? gnt_q : 3'b000;
    rerr_d   = oor_q;
    last_d   = last_q;
`ifdef ARB_CPU_PRIORITY_EN
    // Requester 0's grants leave the 1/2 pointer unchanged.
    if (win_valid && win_id != 2'd0) last_d = win_id;
`else
    if (win_valid) last_d = win_id;
`endif
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    if (!CLR) begin
      gnt_q    <= '0;
      last_q   <= 2'd2;
      addr_q   <= '0;
      din_q    <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      oor_q    <= 1'b0;
      rvalid_q <= '0;
      rerr_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      oor_q    <= oor_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      err_q    <= err_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.mem_wr   = wr_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.err      = err_q;
  // Memory data arrives one cycle after the address, which lines up with the return stage.
  assign bus.rdata    = (|rvalid_q && !rerr_q) ? bus.mem_dout : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench drives the requesters and models an 18x16K synchronous port-B memory.
// The expected grant order in the contention test follows ARB_CPU_PRIORITY_EN.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA(18), .ADDR(14)) bus ();

  mem_port_arbiter #(.DATA(18), .ADDR(14)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  logic [17:0] mem [0:16383];

  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [2:0] who);
    case (who)
      3'b001:  return 32'h2A5A5;
      3'b010:  return 32'h3FFFF;
      3'b100:  return 32'h1ABCD;
      default: return 32'h0;
    endcase
  endfunction

  logic [2:0] exp_gnt [6];
  logic [2:0] prev;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 18'h0;
    mem[16'h0010] = 18'h2A5A5;
    mem[16'h0000] = 18'h1ABCD;
`ifdef ARB_CPU_PRIORITY_EN
    exp_gnt = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010};
`else
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif

    clr = 1'b0;
    bus.req = '0; bus.wr = '0; bus.addr = '0; bus.din = '0;
    tick(); tick();
    clr = 1'b1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_err", bus.err, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_din", bus.mem_din, 0);

    // Requester 0 reads 0x0010.
    bus.addr[15:0] = 16'h0010; bus.wr = 3'b000; bus.req = 3'b001;
    tick();
    check("rd0_gnt", bus.gnt, 3'b001);
    check("rd0_mem_addr", bus.mem_addr, 16'h0010);
    check("rd0_mem_wr", bus.mem_wr, 0);
    check("rd0_rvalid_early", bus.rvalid, 0);
    bus.req = 3'b000;
    tick();
    check("rd0_rvalid", bus.rvalid, 3'b001);
    check("rd0_rdata", bus.rdata, 32'h2A5A5);
    check("rd0_gnt_off", bus.gnt, 0);
    tick();
    check("idle_rvalid", bus.rvalid, 0);
    check("idle_rdata", bus.rdata, 0);
    check("idle_mem_addr_hold", bus.mem_addr, 16'h0010);

    // Requester 1 writes 0x3FFFF to 0x0123, then reads it back.
    bus.addr[31:16] = 16'h0123; bus.din[35:18] = 18'h3FFFF; bus.wr = 3'b010; bus.req = 3'b010;
    tick();
    check("wr1_gnt", bus.gnt, 3'b010);
    check("wr1_mem_wr", bus.mem_wr, 1);
    check("wr1_mem_addr", bus.mem_addr, 16'h0123);
    check("wr1_mem_din", bus.mem_din, 32'h3FFFF);
    bus.wr = 3'b000;
    tick();
    check("wr1_gnt_gap", bus.gnt, 0);
    check("wr1_no_rvalid", bus.rvalid, 0);
    check("wr1_mem_wr_off", bus.mem_wr, 0);
    tick();
    check("rd1_gnt", bus.gnt, 3'b010);
    check("rd1_mem_wr", bus.mem_wr, 0);
    bus.req = 3'b000;
    tick();
    check("rd1_rvalid", bus.rvalid, 3'b010);
    check("rd1_rdata", bus.rdata, 32'h3FFFF);

    // Requester 2 writes out of range, then reads out of range.
    bus.addr[47:32] = 16'hF000; bus.din[53:36] = 18'h15555; bus.wr = 3'b100; bus.req = 3'b100;
    tick();
    check("oor_wr_gnt", bus.gnt, 3'b100);
    check("oor_wr_mem_wr", bus.mem_wr, 0);
    check("oor_wr_err", bus.err, 3'b100);
    bus.addr[47:32] = 16'hC000; bus.wr = 3'b000;
    tick();
    check("oor_wr_no_rvalid", bus.rvalid, 0);
    tick();
    check("oor_rd_gnt", bus.gnt, 3'b100);
    check("oor_rd_mem_addr", bus.mem_addr, 0);
    bus.req = 3'b000;
    tick();
    check("oor_rd_rvalid", bus.rvalid, 3'b100);
    check("oor_rd_rdata", bus.rdata, 0);
    check("oor_err_sticky", bus.err, 3'b100);

    // Reset in the cycle a read is granted.
    bus.addr[15:0] = 16'h0010; bus.req = 3'b001;
    tick();
    check("mid_gnt", bus.gnt, 3'b001);
    clr = 1'b0; bus.req = 3'b000;
    tick();
    check("mid_rst_gnt", bus.gnt, 0);
    check("mid_rst_rvalid", bus.rvalid, 0);
    check("mid_rst_rdata", bus.rdata, 0);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_mem_wr", bus.mem_wr, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_mem_din", bus.mem_din, 0);

    // All three requesters read continuously from reset.
    clr = 1'b1;
    bus.addr[15:0] = 16'h0010; bus.addr[31:16] = 16'h0123; bus.addr[47:32] = 16'h0000;
    bus.wr = 3'b000; bus.req = 3'b111;
    prev = 3'b000;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("cont_gnt_%0d", k), bus.gnt, exp_gnt[k]);
      check($sformatf("cont_rvalid_%0d", k), bus.rvalid, prev);
      check($sformatf("cont_rdata_%0d", k), bus.rdata, exp_rdata(prev));
      prev = exp_gnt[k];
    end
    bus.req = 3'b000;
    tick();
    check("cont_gnt_end", bus.gnt, 0);
    check("cont_rvalid_end", bus.rvalid, prev);
    check("cont_rdata_end", bus.rdata, exp_rdata(prev));
    tick();
    check("cont_quiet", bus.rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
